mem_arbiter: RTL and testbench

Two-port arbiter that shares the A09 single-port synchronous program/data memory between the CPU (port A) and a debug/program-loader master (port B). Sits between both masters and the memory instance: it serialises requests, drives the memory address/data/write strobe from registers, captures read data with the memory's one-cycle latency, and returns a one-cycle acknowledge to the winning master. Round-robin between masters; CPU wins the first tie after reset.

---
 rtl/a09_pkg.sv | 17 +
 rtl/mem_arbiter_rr_pick2.sv | 24 ++
 rtl/mem_arbiter.sv | 125 ++++++++++++
 tb/tb_mem_arbiter.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/a09_pkg.sv
// Shared A09 memory-subsystem definitions: arbiter state encoding, port ids
// and default memory geometry.
package a09_pkg;

    localparam int A09_DATA_WIDTH = 16;
    localparam int A09_ADDR_WIDTH = 8;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        CAPTURE = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// Two-way round-robin selector: a lone requester wins outright, a tie goes to
// the port that was not granted last.
module rr_pick2
    import a09_pkg::*;
(
    input  logic req_a,
    input  logic req_b,
    input  logic last,
    output logic valid,
    output logic winner
);

    assign valid = req_a | req_b;

    always_comb begin
        winner = PORT_A;
        if (req_a && req_b) begin
            winner = ~last;
        end else if (req_b) begin
            winner = PORT_B;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single-port synchronous A09 memory between the CPU (port A) and
// the debug/program loader (port B), one registered access at a time.
module mem_arbiter
    import a09_pkg::*;
#(
    parameter int DATA_WIDTH = A09_DATA_WIDTH,
    parameter int ADDR_WIDTH = A09_ADDR_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  reset_ni,

    input  logic                  a_req_i,
    input  logic                  a_wr_i,
    input  logic [ADDR_WIDTH-1:0] a_addr_i,
    input  logic [DATA_WIDTH-1:0] a_data_i,
    output logic                  a_ack_o,
    output logic [DATA_WIDTH-1:0] a_data_o,

    input  logic                  b_req_i,
    input  logic                  b_wr_i,
    input  logic [ADDR_WIDTH-1:0] b_addr_i,
    input  logic [DATA_WIDTH-1:0] b_data_i,
    output logic                  b_ack_o,
    output logic [DATA_WIDTH-1:0] b_data_o,

    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_data_o,
    output logic                  mem_wr_o,
    input  logic [DATA_WIDTH-1:0] mem_data_i,

    output logic                  busy_o,
    output logic                  owner_o,
    output arb_state_t            state_o
);

    // Handshake: a master raises req with wr/addr/data and holds them until
    // its ack pulses for one cycle; the payload is sampled only at grant, so a
    // master that drops req after grant still receives exactly one ack.

    arb_state_t state;
    logic       last_owner;
    logic       op_wr;
    logic       elig_a;
    logic       elig_b;
    logic       pick_valid;
    logic       pick_winner;

    // A port whose ack is high this cycle is masked so it cannot re-win
    // with the request it is just now retiring.
    assign elig_a = a_req_i & ~a_ack_o;
    assign elig_b = b_req_i & ~b_ack_o;

    rr_pick2 u_pick (
        .req_a  (elig_a),
        .req_b  (elig_b),
        .last   (last_owner),
        .valid  (pick_valid),
        .winner (pick_winner)
    );

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state      <= IDLE;
            last_owner <= PORT_B;
            owner_o    <= PORT_A;
            op_wr      <= 1'b0;
            mem_addr_o <= '0;
            mem_data_o <= '0;
            mem_wr_o   <= 1'b0;
            a_ack_o    <= 1'b0;
            b_ack_o    <= 1'b0;
            a_data_o   <= '0;
            b_data_o   <= '0;
        end else begin
            a_ack_o <= 1'b0;
            b_ack_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        owner_o <= pick_winner;
                        if (pick_winner == PORT_B) begin
                            mem_addr_o <= b_addr_i;
                            mem_data_o <= b_data_i;
                            mem_wr_o   <= b_wr_i;
                            op_wr      <= b_wr_i;
                        end else begin
                            mem_addr_o <= a_addr_i;
                            mem_data_o <= a_data_i;
                            mem_wr_o   <= a_wr_i;
                            op_wr      <= a_wr_i;
                        end
                        state <= ACCESS;
                    end
                end
                ACCESS: begin
                    mem_wr_o <= 1'b0;
                    state    <= CAPTURE;
                end
                CAPTURE: begin
                    if (owner_o == PORT_B) begin
                        b_ack_o <= 1'b1;
                        if (!op_wr) begin
                            b_data_o <= mem_data_i;
                        end
                    end else begin
                        a_ack_o <= 1'b1;
                        if (!op_wr) begin
                            a_data_o <= mem_data_i;
                        end
                    end
                    last_owner <= owner_o;
                    state      <= IDLE;
                end
                default: begin
                    mem_wr_o <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

    assign busy_o  = (state != IDLE);
    assign state_o = state;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural one-cycle-latency memory.
module tb_mem_arbiter;
    import a09_pkg::*;

    logic        clk = 1'b0;
    logic        reset_ni;
    logic        a_req, a_wr, b_req, b_wr;
    logic [7:0]  a_addr, b_addr;
    logic [15:0] a_wdata, b_wdata;
    logic        a_ack, b_ack;
    logic [15:0] a_rdata, b_rdata;
    logic [7:0]  mem_addr;
    logic [15:0] mem_wdata, mem_rdata;
    logic        mem_wr, busy, owner;
    arb_state_t  dbg_state;

    int errors = 0;
    int checks = 0;
    logic [15:0] a_sh = '0;
    logic [15:0] b_sh = '0;

    // Memory environment: write on strobe, read data valid the cycle after.
    logic [15:0] mem_model [256];
    bit          written   [256];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_wr) begin
            mem_model[mem_addr] <= mem_wdata;
            written[mem_addr]   <= 1'b1;
        end
        mem_rdata <= written[mem_addr] ? mem_model[mem_addr] : (16'hA000 | {8'h00, mem_addr});
    end

    mem_arbiter dut (
        .clk_i(clk), .reset_ni(reset_ni),
        .a_req_i(a_req), .a_wr_i(a_wr), .a_addr_i(a_addr), .a_data_i(a_wdata),
        .a_ack_o(a_ack), .a_data_o(a_rdata),
        .b_req_i(b_req), .b_wr_i(b_wr), .b_addr_i(b_addr), .b_data_i(b_wdata),
        .b_ack_o(b_ack), .b_data_o(b_rdata),
        .mem_addr_o(mem_addr), .mem_data_o(mem_wdata), .mem_wr_o(mem_wr),
        .mem_data_i(mem_rdata),
        .busy_o(busy), .owner_o(owner), .state_o(dbg_state)
    );

    typedef struct {
        bit          port;
        bit          wr;
        logic [7:0]  addr;
        logic [15:0] data;
        logic [15:0] exp;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Single transaction from one port; called just after a falling edge.
    task automatic xfer(input vec_t v, input string tag);
        int lat = 0;
        int wr_cnt = 0;
        int other_acks = 0;
        if (v.port) begin
            b_req = 1'b1; b_wr = v.wr; b_addr = v.addr; b_wdata = v.data;
        end else begin
            a_req = 1'b1; a_wr = v.wr; a_addr = v.addr; a_wdata = v.data;
        end
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c == 1) begin
                chk({tag, "_owner"}, 32'(owner), 32'(v.port));
                chk({tag, "_maddr"}, 32'(mem_addr), 32'(v.addr));
                if (v.wr) chk({tag, "_mdata"}, 32'(mem_wdata), 32'(v.data));
            end
            if (mem_wr) wr_cnt++;
            if ((v.port ? a_ack : b_ack) == 1'b1) other_acks++;
            if ((v.port ? b_ack : a_ack) == 1'b1) begin
                lat = c;
                break;
            end
        end
        a_req = 1'b0;
        b_req = 1'b0;
        chk({tag, "_lat"}, 32'(lat), 32'd3);
        chk({tag, "_wrcnt"}, 32'(wr_cnt), 32'(v.wr));
        chk({tag, "_xack"}, 32'(other_acks), 32'd0);
        if (!v.wr) begin
            if (v.port) b_sh = v.exp; else a_sh = v.exp;
        end
        chk({tag, "_adata"}, 32'(a_rdata), 32'(a_sh));
        chk({tag, "_bdata"}, 32'(b_rdata), 32'(b_sh));
        @(negedge clk);
        chk({tag, "_ackoff"}, 32'({a_ack, b_ack}), 32'd0);
    endtask

    vec_t vecs [9];

    initial begin
        int a_lat, b_lat, last_ack, n_acks, both_hi;
        bit exp_port;

        vecs[0] = '{1'b0, 1'b1, 8'h05, 16'hBEEF, 16'h0000};
        vecs[1] = '{1'b0, 1'b0, 8'h05, 16'h0000, 16'hBEEF};
        vecs[2] = '{1'b1, 1'b0, 8'h05, 16'h0000, 16'hBEEF};
        vecs[3] = '{1'b1, 1'b1, 8'h20, 16'hCAFE, 16'h0000};
        vecs[4] = '{1'b0, 1'b0, 8'h20, 16'h0000, 16'hCAFE};
        vecs[5] = '{1'b0, 1'b0, 8'h0E, 16'h0000, 16'h1242};
        vecs[6] = '{1'b1, 1'b1, 8'hFF, 16'h0F0F, 16'h0000};
        vecs[7] = '{1'b0, 1'b0, 8'hFF, 16'h0000, 16'h0F0F};
        vecs[8] = '{1'b1, 1'b0, 8'h00, 16'h0000, 16'h1234};

        // Reset held with a pending CPU write.
        reset_ni = 1'b0;
        a_req = 1'b1; a_wr = 1'b1; a_addr = 8'h10; a_wdata = 16'h5555;
        b_req = 1'b0; b_wr = 1'b0; b_addr = '0; b_wdata = '0;
        repeat (2) begin
            @(negedge clk);
            chk("rst_memwr", 32'(mem_wr), 32'd0);
            chk("rst_acks", 32'({a_ack, b_ack}), 32'd0);
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_owner", 32'(owner), 32'd0);
            chk("rst_state", 32'(dbg_state), 32'(IDLE));
            chk("rst_maddr", 32'(mem_addr), 32'd0);
            chk("rst_data", 32'({a_rdata, b_rdata}), 32'd0);
        end
        reset_ni = 1'b1;
        @(negedge clk);
        chk("post_rst_busy", 32'(busy), 32'd1);
        chk("post_rst_memwr", 32'(mem_wr), 32'd1);
        chk("post_rst_maddr", 32'(mem_addr), 32'h10);
        a_req = 1'b0;
        a_lat = 0;
        for (int c = 2; c <= 8; c++) begin
            @(negedge clk);
            if (a_ack) begin a_lat = c; break; end
        end
        chk("post_rst_lat", 32'(a_lat), 32'd3);
        @(negedge clk);

        // Reset asserted during the ACCESS cycle of a write.
        a_req = 1'b1; a_wr = 1'b1; a_addr = 8'h30; a_wdata = 16'h7777;
        @(negedge clk);
        chk("abort_memwr_pre", 32'(mem_wr), 32'd1);
        a_req = 1'b0;
        #1 reset_ni = 1'b0;
        #1;
        chk("abort_memwr", 32'(mem_wr), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_maddr", 32'(mem_addr), 32'd0);
        @(negedge clk);
        reset_ni = 1'b1;
        @(negedge clk);
        chk("abort_idle", 32'(busy), 32'd0);
        chk("abort_nowrite", 32'(written[8'h30]), 32'd0);

        // Loader preload, B requesting back to back.
        b_req = 1'b1; b_wr = 1'b1; b_addr = 8'h00; b_wdata = 16'h1234;
        n_acks = 0; last_ack = 0;
        for (int c = 1; c <= 100 && n_acks < 15; c++) begin
            @(negedge clk);
            if (a_ack) chk("pre_aack", 32'(a_ack), 32'd0);
            if (b_ack) begin
                if (n_acks == 0) chk("pre_lat0", 32'(c), 32'd3);
                else chk("pre_gap", 32'(c - last_ack), 32'd4);
                last_ack = c;
                n_acks++;
                b_addr = 8'(n_acks);
                b_wdata = 16'h1234 + 16'(n_acks);
                if (n_acks == 15) b_req = 1'b0;
            end
        end
        b_req = 1'b0;
        chk("pre_count", 32'(n_acks), 32'd15);
        chk("pre_adata", 32'(a_rdata), 32'd0);
        for (int i = 0; i < 15; i++) begin
            chk("pre_mem", {16'(i), mem_model[i]}, {16'(i), 16'h1234 + 16'(i)});
        end
        @(negedge clk);

        // Simultaneous requests: A has priority on the tie.
        a_req = 1'b1; a_wr = 1'b0; a_addr = 8'h01;
        b_req = 1'b1; b_wr = 1'b0; b_addr = 8'h02;
        a_lat = 0; b_lat = 0; both_hi = 0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (c == 1) chk("tie_owner", 32'(owner), 32'd0);
            if (a_ack && b_ack) both_hi++;
            if (a_ack && a_lat == 0) begin a_lat = c; a_req = 1'b0; end
            if (b_ack && b_lat == 0) begin b_lat = c; b_req = 1'b0; end
        end
        a_req = 1'b0; b_req = 1'b0;
        chk("tie_alat", 32'(a_lat), 32'd3);
        chk("tie_blat", 32'(b_lat), 32'd6);
        chk("tie_both", 32'(both_hi), 32'd0);
        chk("tie_adata", 32'(a_rdata), 32'h1235);
        chk("tie_bdata", 32'(b_rdata), 32'h1236);
        a_sh = 16'h1235;
        b_sh = 16'h1236;

        for (int i = 0; i < 9; i++) begin
            xfer(vecs[i], $sformatf("vec%0d", i));
        end

        // Continuous contention: grants must alternate starting with A.
        a_req = 1'b1; a_wr = 1'b0; a_addr = 8'h05;
        b_req = 1'b1; b_wr = 1'b0; b_addr = 8'h20;
        exp_port = 1'b0; n_acks = 0; last_ack = 0;
        for (int c = 1; c <= 60 && n_acks < 10; c++) begin
            @(negedge clk);
            if (a_ack || b_ack) begin
                chk("cont_port", 32'({a_ack, b_ack}), exp_port ? 32'd1 : 32'd2);
                chk("cont_owner", 32'(owner), 32'(exp_port));
                if (a_ack) chk("cont_adata", 32'(a_rdata), 32'hBEEF);
                if (b_ack) chk("cont_bdata", 32'(b_rdata), 32'hCAFE);
                if (n_acks > 0) chk("cont_gap", 32'(c - last_ack), 32'd3);
                last_ack = c;
                exp_port = ~exp_port;
                n_acks++;
                if (n_acks == 10) begin a_req = 1'b0; b_req = 1'b0; end
            end
        end
        a_req = 1'b0; b_req = 1'b0;
        chk("cont_count", 32'(n_acks), 32'd10);
        @(negedge clk);
        chk("cont_idle", 32'(busy), 32'd0);

        // Request dropped and address changed after grant.
        a_req = 1'b1; a_wr = 1'b0; a_addr = 8'h03;
        @(negedge clk);
        chk("viol_maddr", 32'(mem_addr), 32'h03);
        a_req = 1'b0; a_addr = 8'hFF;
        n_acks = 0; a_lat = 0;
        for (int c = 2; c <= 10; c++) begin
            @(negedge clk);
            if (a_ack) begin
                n_acks++;
                if (a_lat == 0) a_lat = c;
                chk("viol_data", 32'(a_rdata), 32'h1237);
            end
        end
        chk("viol_lat", 32'(a_lat), 32'd3);
        chk("viol_acks", 32'(n_acks), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog");
    end

endmodule
